// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the M-stage data-memory sequencer: FSM states, bus
// size codes, one-hot op bit positions and the alignment rule.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Bit positions inside the pipeline's one-hot load vector {lb,lbu,lh,lhu,lw,lwl,lwr}
  localparam int LD_LB  = 6;
  localparam int LD_LBU = 5;
  localparam int LD_LH  = 4;
  localparam int LD_LHU = 3;
  localparam int LD_LW  = 2;
  localparam int LD_LWL = 1;
  localparam int LD_LWR = 0;

  // Bit positions inside the one-hot store vector {sb,sh,sw,swl,swr}
  localparam int ST_SB  = 4;
  localparam int ST_SH  = 3;
  localparam int ST_SW  = 2;
  localparam int ST_SWL = 1;
  localparam int ST_SWR = 0;

  // Bit positions inside the extension unit's 9-bit type vector
  localparam int EXT_LB  = 8;
  localparam int EXT_LBU = 7;
  localparam int EXT_LH  = 6;
  localparam int EXT_LHU = 5;
  localparam int EXT_LW  = 4;
  localparam int EXT_LWL = 3;
  localparam int EXT_LWR = 2;

  // Unaligned lwl/lwr/swl/swr are legal by design; only natural-size ops can fault.
  function automatic logic is_misaligned(input logic [6:0] ld, input logic [4:0] st,
                                         input logic [1:0] off);
    return ((ld[LD_LH] | ld[LD_LHU] | st[ST_SH]) & off[0]) |
           ((ld[LD_LW] | st[ST_SW]) & (off != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_store_align.sv
// Combinational store lane steering: byte strobes, lane-shifted write data and
// bus size for a one-hot store type and the address byte offset.
module dmem_store_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [4:0]  st_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_aligned_o,
  output logic [1:0]  size_o
);

  logic [1:0] inv_off;
  assign inv_off = 2'd3 - offset_i;

  always_comb begin
    // NOTE: every output gets a default before the branches so no path can infer a latch.
    wstrb_o         = 4'b0000;
    wdata_aligned_o = wdata_i;
    size_o          = SIZE_WORD;
    if (st_type_i[ST_SB]) begin
      size_o          = SIZE_BYTE;
      wstrb_o         = 4'b0001 << offset_i;
      wdata_aligned_o = {4{wdata_i[7:0]}};
    end else if (st_type_i[ST_SH]) begin
      size_o          = SIZE_HALF;
      wstrb_o         = 4'b0011 << offset_i;
      wdata_aligned_o = {2{wdata_i[15:0]}};
    end else if (st_type_i[ST_SW]) begin
      wstrb_o         = 4'b1111;
    end else if (st_type_i[ST_SWL]) begin
      wstrb_o         = 4'b1111 >> inv_off;
      wdata_aligned_o = wdata_i >> {inv_off, 3'b000};
    end else if (st_type_i[ST_SWR]) begin
      wstrb_o         = 4'b1111 << offset_i;
      wdata_aligned_o = wdata_i << {offset_i, 3'b000};
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory sequencer: issues one aligned load/store on the sram-like
// bus, stalls the pipe while it is outstanding and hands load words to extension.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // byte-lane logic is 4-lane only; keep at 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic [6:0]        m_ld_type,
  input  logic [4:0]        m_st_type,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              m_flush,
  output logic              m_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_raw,
  output logic [1:0]        ld_offset,
  output logic [8:0]        ld_type,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] exc_badvaddr
);

  state_e            state_q;
  logic [6:0]        ld_q;
  logic [4:0]        st_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ld_done_q, exc_adel_q, exc_ades_q;
  logic [DATA_W-1:0] ld_raw_q;
  logic [1:0]        ld_offset_q;
  logic [8:0]        ld_type_q;
  logic [ADDR_W-1:0] badvaddr_q;

  logic in_is_ld, in_is_st, in_op, in_misaligned, issue;

  assign in_is_ld      = |m_ld_type;
  assign in_is_st      = |m_st_type;
  assign in_op         = m_valid & (in_is_ld | in_is_st);
  assign in_misaligned = is_misaligned(m_ld_type, m_st_type, m_addr[1:0]);
  // Zero-latency issue straight from the pipeline register; never while held in reset.
  assign issue = resetn & (state_q == S_IDLE) & in_op & ~m_flush & ~in_misaligned;

  // The issue cycle drives the bus from the inputs; REQ replays the latched copy.
  logic [6:0]        cur_ld;
  logic [4:0]        cur_st;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              use_in;

  assign use_in    = (state_q == S_IDLE);
  assign cur_ld    = use_in ? m_ld_type : ld_q;
  assign cur_st    = use_in ? m_st_type : st_q;
  assign cur_addr  = use_in ? m_addr    : addr_q;
  assign cur_wdata = use_in ? m_wdata   : wdata_q;

  logic [3:0]        st_wstrb;
  logic [DATA_W-1:0] st_wdata;
  logic [1:0]        st_size;

  dmem_store_align u_store_align (
    .st_type_i       (cur_st),
    .offset_i        (cur_addr[1:0]),
    .wdata_i         (cur_wdata),
    .wstrb_o         (st_wstrb),
    .wdata_aligned_o (st_wdata),
    .size_o          (st_size)
  );

  logic word_op, req;
  assign word_op = cur_ld[LD_LW] | cur_ld[LD_LWL] | cur_ld[LD_LWR] |
                   cur_st[ST_SW] | cur_st[ST_SWL] | cur_st[ST_SWR];
  assign req     = issue | (state_q == S_REQ);

  always_comb begin
    data_req   = req;
    data_wr    = 1'b0;
    data_size  = 2'b00;
    data_addr  = '0;
    data_wstrb = 4'b0000;
    data_wdata = '0;
    if (req) begin
      data_wr   = |cur_st;
      data_addr = word_op ? {cur_addr[ADDR_W-1:2], 2'b00} : cur_addr;
      if (|cur_st) begin
        data_size  = st_size;
        data_wstrb = st_wstrb;
        data_wdata = st_wdata;
      end else if (cur_ld[LD_LB] | cur_ld[LD_LBU]) begin
        data_size = SIZE_BYTE;
      end else if (cur_ld[LD_LH] | cur_ld[LD_LHU]) begin
        data_size = SIZE_HALF;
      end else begin
        data_size = SIZE_WORD;
      end
    end
  end

  // In DRAIN the flushed op no longer owns the pipe; only a new op must wait.
  always_comb begin
    m_stall = 1'b0;
    unique case (state_q)
      S_IDLE:         m_stall = issue;
      S_REQ, S_WAIT:  m_stall = 1'b1;
      S_DRAIN:        m_stall = in_op;
      default:        m_stall = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ld_q        <= '0;
      st_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ld_done_q   <= 1'b0;
      exc_adel_q  <= 1'b0;
      exc_ades_q  <= 1'b0;
      ld_raw_q    <= '0;
      ld_offset_q <= '0;
      ld_type_q   <= '0;
      badvaddr_q  <= '0;
    end else begin
      ld_done_q  <= 1'b0;
      exc_adel_q <= 1'b0;
      exc_ades_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_op && !m_flush) begin
            if (in_misaligned) begin
              exc_adel_q <= in_is_ld;
              exc_ades_q <= ~in_is_ld;
              badvaddr_q <= m_addr;
            end else begin
              ld_q    <= m_ld_type;
              st_q    <= m_st_type;
              addr_q  <= m_addr;
              wdata_q <= m_wdata;
              state_q <= data_addr_ok ? S_WAIT : S_REQ;
            end
          end
        end
        S_REQ: begin
          if (data_addr_ok)  state_q <= m_flush ? S_DRAIN : S_WAIT;
          else if (m_flush)  state_q <= S_IDLE;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            state_q <= S_IDLE;
            // A flush landing on the completion cycle still kills the load result.
            if ((|ld_q) && !m_flush) begin
              ld_done_q   <= 1'b1;
              ld_raw_q    <= data_rdata;
              ld_offset_q <= addr_q[1:0];
              ld_type_q   <= {ld_q, 2'b00};
            end
          end else if (m_flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (data_data_ok) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ld_done      = ld_done_q;
  assign ld_raw       = ld_raw_q;
  assign ld_offset    = ld_offset_q;
  assign ld_type      = ld_type_q;
  assign exc_adel     = exc_adel_q;
  assign exc_ades     = exc_ades_q;
  assign exc_badvaddr = badvaddr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: bus fields checked inline, completion and
// exception pulses checked against a scoreboard queue filled when stimulus is driven.
module tb_dmem_access_ctrl;

  localparam logic [6:0] LH  = 7'b0010000;
  localparam logic [6:0] LW  = 7'b0000100;
  localparam logic [6:0] LWL = 7'b0000010;
  localparam logic [4:0] SB  = 5'b10000;
  localparam logic [4:0] SH  = 5'b01000;
  localparam logic [4:0] SW  = 5'b00100;
  localparam logic [4:0] SWL = 5'b00010;
  localparam logic [4:0] SWR = 5'b00001;

  localparam logic [2:0] EV_LOAD = 3'b100;
  localparam logic [2:0] EV_ADEL = 3'b010;
  localparam logic [2:0] EV_ADES = 3'b001;

  logic        clk, resetn;
  logic        m_valid, m_flush;
  logic [6:0]  m_ld_type;
  logic [4:0]  m_st_type;
  logic [31:0] m_addr, m_wdata;
  logic        m_stall;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        ld_done;
  logic [31:0] ld_raw;
  logic [1:0]  ld_offset;
  logic [8:0]  ld_type;
  logic        exc_adel, exc_ades;
  logic [31:0] exc_badvaddr;

  dmem_access_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .m_valid      (m_valid),
    .m_ld_type    (m_ld_type),
    .m_st_type    (m_st_type),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_flush      (m_flush),
    .m_stall      (m_stall),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .ld_done      (ld_done),
    .ld_raw       (ld_raw),
    .ld_offset    (ld_offset),
    .ld_type      (ld_type),
    .exc_adel     (exc_adel),
    .exc_ades     (exc_ades),
    .exc_badvaddr (exc_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] raw;
    logic [1:0]  off;
    logic [8:0]  typ;
    logic [31:0] badva;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_op();
    m_valid   = 1'b0;
    m_ld_type = '0;
    m_st_type = '0;
  endtask

  // Pulse outputs are compared against the scoreboard whenever they appear.
  always @(negedge clk) begin
    if (ld_done || exc_adel || exc_ades) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'b0, ld_done, exc_adel, exc_ades}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("evt_kind", {29'b0, ld_done, exc_adel, exc_ades}, {29'b0, mon_e.kind});
        if (mon_e.kind == EV_LOAD) begin
          check("evt_ld_raw",    ld_raw,            mon_e.raw);
          check("evt_ld_offset", {30'b0, ld_offset}, {30'b0, mon_e.off});
          check("evt_ld_type",   {23'b0, ld_type},   {23'b0, mon_e.typ});
        end else begin
          check("evt_badvaddr", exc_badvaddr, mon_e.badva);
        end
      end
    end
  end

  // Single-beat store: accepted in the issue cycle, completed one cycle later.
  task automatic do_store(input string tag, input logic [4:0] st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input logic [31:0] e_addr,
                          input logic [1:0] e_size);
    m_valid = 1'b1; m_ld_type = '0; m_st_type = st; m_addr = a; m_wdata = wd;
    data_addr_ok = 1'b1;
    @(negedge clk);
    check({tag, "_req"},   {31'b0, data_req},   32'd1);
    check({tag, "_wr"},    {31'b0, data_wr},    32'd1);
    check({tag, "_strb"},  {28'b0, data_wstrb}, {28'b0, e_strb});
    check({tag, "_wdata"}, data_wdata,          e_wdata);
    check({tag, "_addr"},  data_addr,           e_addr);
    check({tag, "_size"},  {30'b0, data_size},  {30'b0, e_size});
    check({tag, "_stall0"}, {31'b0, m_stall},   32'd1);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    @(negedge clk);
    check({tag, "_stall1"}, {31'b0, m_stall},  32'd1);
    check({tag, "_req_wait"}, {31'b0, data_req}, 32'd0);
    cyc();
    data_data_ok = 1'b0; idle_op();
    @(negedge clk);
    check({tag, "_stall2"}, {31'b0, m_stall},  32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // NOTE: the bench drives inputs with blocking assignments from this one initial block.
    resetn = 1'b0; m_flush = 1'b0; idle_op();
    m_addr = '0; m_wdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    @(negedge clk);
    check("rst_req",      {31'b0, data_req},  32'd0);
    check("rst_stall",    {31'b0, m_stall},   32'd0);
    check("rst_ld_done",  {31'b0, ld_done},   32'd0);
    check("rst_exc",      {30'b0, exc_adel, exc_ades}, 32'd0);
    check("rst_ld_raw",   ld_raw,             32'd0);
    check("rst_ld_type",  {23'b0, ld_type},   32'd0);
    check("rst_badvaddr", exc_badvaddr,       32'd0);
    cyc();
    resetn = 1'b1;
    cyc();

    // Word store, two stall cycles, no load completion.
    do_store("sw", SW, 32'h100, 32'h11223344, 4'b1111, 32'h11223344, 32'h100, 2'd0 + 2'd2);

    // Byte store with a one-cycle accept delay; REQ must replay the latched fields.
    m_valid = 1'b1; m_st_type = SB; m_addr = 32'h103; m_wdata = 32'h000000AB;
    @(negedge clk);
    check("sb_strb",  {28'b0, data_wstrb}, 32'h8);
    check("sb_wdata", data_wdata,          32'hABABABAB);
    check("sb_size",  {30'b0, data_size},  32'd0);
    check("sb_addr",  data_addr,           32'h103);
    cyc();
    m_wdata = 32'h0; data_addr_ok = 1'b1;
    @(negedge clk);
    check("sb_req_hold",   {31'b0, data_req}, 32'd1);
    check("sb_wdata_hold", data_wdata,        32'hABABABAB);
    check("sb_strb_hold",  {28'b0, data_wstrb}, 32'h8);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    cyc();
    data_data_ok = 1'b0; idle_op();
    cyc();

    do_store("swl", SWL, 32'h101, 32'hAABBCCDD, 4'b0011, 32'h0000AABB, 32'h100, 2'd2);
    do_store("swr", SWR, 32'h502, 32'h11223344, 4'b1100, 32'h33440000, 32'h500, 2'd2);
    do_store("sh",  SH,  32'h102, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF, 32'h102, 2'd1);

    // Halfword load with three wait cycles before data.
    m_valid = 1'b1; m_ld_type = LH; m_addr = 32'h102; data_addr_ok = 1'b1;
    @(negedge clk);
    check("lh_req",  {31'b0, data_req},   32'd1);
    check("lh_wr",   {31'b0, data_wr},    32'd0);
    check("lh_addr", data_addr,           32'h102);
    check("lh_size", {30'b0, data_size},  32'd1);
    check("lh_strb", {28'b0, data_wstrb}, 32'd0);
    cyc();
    data_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lh_wait_stall", {31'b0, m_stall},  32'd1);
      check("lh_wait_req",   {31'b0, data_req}, 32'd0);
      cyc();
    end
    data_data_ok = 1'b1; data_rdata = 32'h87651234;
    sb.push_back('{kind: EV_LOAD, raw: 32'h87651234, off: 2'd2, typ: 9'h040, badva: 32'h0});
    @(negedge clk);
    check("lh_dok_stall", {31'b0, m_stall}, 32'd1);
    cyc();
    data_data_ok = 1'b0; data_rdata = 32'h0; idle_op();
    @(negedge clk);
    check("lh_done",       {31'b0, ld_done}, 32'd1);
    check("lh_done_stall", {31'b0, m_stall}, 32'd0);
    cyc();

    // Misaligned load and store: exception pulse, no bus request.
    m_valid = 1'b1; m_ld_type = LW; m_addr = 32'h102;
    sb.push_back('{kind: EV_ADEL, raw: 32'h0, off: 2'd0, typ: 9'h0, badva: 32'h102});
    @(negedge clk);
    check("adel_req",   {31'b0, data_req}, 32'd0);
    check("adel_stall", {31'b0, m_stall},  32'd0);
    cyc();
    idle_op();
    @(negedge clk);
    check("adel_pulse", {31'b0, exc_adel}, 32'd1);
    cyc();
    m_valid = 1'b1; m_st_type = SH; m_addr = 32'h101;
    sb.push_back('{kind: EV_ADES, raw: 32'h0, off: 2'd0, typ: 9'h0, badva: 32'h101});
    @(negedge clk);
    check("ades_req", {31'b0, data_req}, 32'd0);
    cyc();
    idle_op();
    @(negedge clk);
    check("ades_pulse", {31'b0, exc_ades}, 32'd1);
    cyc();
    @(negedge clk);
    check("ades_cleared", {31'b0, exc_ades}, 32'd0);
    cyc();

    // Flush during WAIT: the load is drained, the next op waits for the stray data_ok.
    m_valid = 1'b1; m_ld_type = LW; m_addr = 32'h200; data_addr_ok = 1'b1;
    @(negedge clk);
    check("fl_req", {31'b0, data_req}, 32'd1);
    cyc();
    data_addr_ok = 1'b0; m_flush = 1'b1;
    cyc();
    m_flush = 1'b0; idle_op();
    @(negedge clk);
    check("fl_drain_stall", {31'b0, m_stall},  32'd0);
    check("fl_drain_req",   {31'b0, data_req}, 32'd0);
    cyc();
    m_valid = 1'b1; m_st_type = SW; m_addr = 32'h300; m_wdata = 32'h55667788;
    data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("fl_hold_stall", {31'b0, m_stall},  32'd1);
    check("fl_hold_req",   {31'b0, data_req}, 32'd0);
    cyc();
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    check("fl_next_req",  {31'b0, data_req}, 32'd1);
    check("fl_next_addr", data_addr,         32'h300);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    cyc();
    data_data_ok = 1'b0; idle_op();
    @(negedge clk);
    check("fl_idle_stall", {31'b0, m_stall}, 32'd0);
    check("ld_raw_held",   ld_raw,           32'h87651234);
    check("ld_type_held",  {23'b0, ld_type}, 32'h040);
    cyc();

    // Flush while the request is still unaccepted drops it.
    m_valid = 1'b1; m_ld_type = LWL; m_addr = 32'h503;
    @(negedge clk);
    check("lwl_addr", data_addr,          32'h500);
    check("lwl_size", {30'b0, data_size}, 32'd2);
    cyc();
    m_flush = 1'b1;
    @(negedge clk);
    check("reqfl_req_held", {31'b0, data_req}, 32'd1);
    cyc();
    m_flush = 1'b0; idle_op();
    @(negedge clk);
    check("reqfl_req",   {31'b0, data_req}, 32'd0);
    check("reqfl_stall", {31'b0, m_stall},  32'd0);
    cyc();

    // Asynchronous reset while in REQ, orphan data_ok, then a normal word load.
    m_valid = 1'b1; m_ld_type = LW; m_addr = 32'h400;
    cyc();
    @(negedge clk);
    check("rq_req", {31'b0, data_req}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("rq_rst_req",   {31'b0, data_req}, 32'd0);
    check("rq_rst_stall", {31'b0, m_stall},  32'd0);
    idle_op();
    cyc();
    resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h12345678;
    @(negedge clk);
    check("orphan_req", {31'b0, data_req}, 32'd0);
    cyc();
    data_data_ok = 1'b0;
    m_valid = 1'b1; m_ld_type = LW; m_addr = 32'h400; data_addr_ok = 1'b1;
    @(negedge clk);
    check("lw_req",  {31'b0, data_req},  32'd1);
    check("lw_addr", data_addr,          32'h400);
    check("lw_size", {30'b0, data_size}, 32'd2);
    cyc();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    sb.push_back('{kind: EV_LOAD, raw: 32'hCAFEF00D, off: 2'd0, typ: 9'h010, badva: 32'h0});
    cyc();
    data_data_ok = 1'b0; idle_op();
    @(negedge clk);
    check("lw_done", {31'b0, ld_done}, 32'd1);
    cyc();
    @(negedge clk);
    check("lw_done_pulse", {31'b0, ld_done}, 32'd0);
    cyc();
    cyc();

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
